// File: rtl/mdl_bdy_stream_tx.sv
// BRAM-to-AXIS coefficient streamer: reads coefficient pairs and emits one 64-bit beat per pair.
// Optional stall counter output oSTALL_CNT is enabled by defining MDL_TX_STALL_CNT_EN.
module mdl_bdy_stream_tx #(
  parameter int PRM_ADDR   = 12,
  parameter int PRM_COEFFS = 4096,
  parameter int PRM_DRAM   = 32,
  parameter int PRM_DAXI   = 64
) (
  input  logic                iSYS_CLK,
  input  logic                iSYS_RST,
  input  logic                iFSM_START,
  output logic                oFSM_DONE,
  output logic                oB_en,
  output logic [PRM_ADDR-1:0] oB_addrA,
  output logic [PRM_ADDR-1:0] oB_addrB,
  input  logic [PRM_DRAM-1:0] iB_doutA,
  input  logic [PRM_DRAM-1:0] iB_doutB,
  output logic                oWm_Tvalid,
  input  logic                iWm_Tready,
  output logic [PRM_DAXI-1:0] oWm_Tdata,
  output logic                oWm_Tlast
`ifdef MDL_TX_STALL_CNT_EN
  ,
  output logic [15:0]         oSTALL_CNT
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [PRM_ADDR-1:0] LAST_ADDR = PRM_ADDR'(PRM_COEFFS - 2);
  localparam logic [PRM_ADDR-1:0] LAST_BEAT = PRM_ADDR'(PRM_COEFFS / 2 - 1);

  logic [1:0]          state_q, state_d;
  logic [PRM_ADDR-1:0] addr_q, addr_d;
  logic [PRM_ADDR-1:0] beat_q, beat_d;
  logic                rd_vld_q, rd_vld_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [PRM_DAXI-1:0] mem_q [2];
  logic [PRM_DAXI-1:0] mem_d [2];

  logic [PRM_DAXI-1:0] rdata_s;
  logic [PRM_DAXI-1:0] tdata_s;
  logic                tvalid_s;
  logic                tlast_s;
  logic                hs_s;
  logic                pop_s;
  logic                push_s;
  logic                issue_s;

  // Output stage: buffered head first, otherwise the BRAM data arriving this cycle falls through.
  always_comb begin
    rdata_s  = {iB_doutB, iB_doutA};
    tvalid_s = (cnt_q != 2'd0) || rd_vld_q;
    if (cnt_q != 2'd0) begin
      tdata_s = mem_q[rd_ptr_q];
    end else if (rd_vld_q) begin
      tdata_s = rdata_s;
    end else begin
      tdata_s = '0;
    end
    tlast_s = tvalid_s && (beat_q == LAST_BEAT);
    hs_s    = tvalid_s && iWm_Tready;
    pop_s   = hs_s && (cnt_q != 2'd0);
    push_s  = rd_vld_q && !(hs_s && (cnt_q == 2'd0));
    issue_s = (state_q == ST_RUN) && (({1'b0, rd_vld_q} + cnt_q) < 2'd2);
  end

  // Buffer bookkeeping: occupancy, pointers and entry writes.
  always_comb begin
    mem_d    = mem_q;
    rd_vld_d = issue_s;
    rd_ptr_d = pop_s ? ~rd_ptr_q : rd_ptr_q;
    wr_ptr_d = push_s ? ~wr_ptr_q : wr_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = rdata_s;
    end else begin
      mem_d = mem_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Frame sequencing and read address generation.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (hs_s) begin
      beat_d = beat_q + PRM_ADDR'(1);
    end else begin
      beat_d = beat_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (iFSM_START) begin
          state_d = ST_RUN;
          addr_d  = '0;
          beat_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (issue_s && (addr_q == LAST_ADDR)) begin
          addr_d  = '0;
          state_d = ST_DRAIN;
        end else if (issue_s) begin
          addr_d = addr_q + PRM_ADDR'(2);
        end else begin
          addr_d = addr_q;
        end
      end
      ST_DRAIN: begin
        if (hs_s && tlast_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; a reset mid-frame drops everything in flight.
  always_ff @(posedge iSYS_CLK) begin
    if (iSYS_RST) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      beat_q   <= '0;
      rd_vld_q <= 1'b0;
      cnt_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      rd_vld_q <= rd_vld_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
    end
  end

  assign oB_en      = issue_s;
  assign oB_addrA   = addr_q;
  assign oB_addrB   = {addr_q[PRM_ADDR-1:1], 1'b1};
  assign oWm_Tvalid = tvalid_s;
  assign oWm_Tdata  = tdata_s;
  assign oWm_Tlast  = tlast_s;
  assign oFSM_DONE  = (state_q == ST_DONE);

`ifdef MDL_TX_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Backpressure counter: cleared by an accepted start, saturating, held after the frame.
  always_comb begin
    if ((state_q == ST_IDLE) && iFSM_START) begin
      stall_d = 16'd0;
    end else if (tvalid_s && !iWm_Tready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge iSYS_CLK) begin
    if (iSYS_RST) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign oSTALL_CNT = stall_q;
`endif

endmodule

// File: tb/tb_mdl_bdy_stream_tx.sv
// Directed bench for mdl_bdy_stream_tx: an 8-coefficient instance for framing/backpressure/reset
// cases and a default 4096-coefficient instance for the alternating-ready full frame.
module tb_mdl_bdy_stream_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_beat(input int k);
    logic [31:0] lo;
    logic [31:0] hi;
    lo = 32'h100 + 32'(2 * k);
    hi = 32'h101 + 32'(2 * k);
    return {hi, lo};
  endfunction

  // ---------------- small instance, PRM_COEFFS = 8 ----------------
  logic        s_rst = 1'b1, s_start = 1'b0, s_rdy = 1'b1;
  logic        s_done, s_en, s_vld, s_last;
  logic [11:0] s_addrA, s_addrB;
  logic [31:0] s_doutA = 32'd0, s_doutB = 32'd0;
  logic [63:0] s_data;
  logic [15:0] s_stall;

  mdl_bdy_stream_tx #(.PRM_ADDR(12), .PRM_COEFFS(8), .PRM_DRAM(32), .PRM_DAXI(64)) u_small (
    .iSYS_CLK(clk), .iSYS_RST(s_rst), .iFSM_START(s_start), .oFSM_DONE(s_done),
    .oB_en(s_en), .oB_addrA(s_addrA), .oB_addrB(s_addrB),
    .iB_doutA(s_doutA), .iB_doutB(s_doutB),
    .oWm_Tvalid(s_vld), .iWm_Tready(s_rdy), .oWm_Tdata(s_data), .oWm_Tlast(s_last)
`ifdef MDL_TX_STALL_CNT_EN
    , .oSTALL_CNT(s_stall)
`endif
  );
`ifndef MDL_TX_STALL_CNT_EN
  assign s_stall = 16'd0;
`endif

  always @(posedge clk) begin
    if (s_en) begin
      s_doutA <= 32'h100 + {20'd0, s_addrA};
      s_doutB <= 32'h100 + {20'd0, s_addrB};
    end
  end

  // ---------------- big instance, default parameters ----------------
  logic        b_rst = 1'b1, b_start = 1'b0, b_rdy = 1'b0;
  logic        b_done, b_en, b_vld, b_last;
  logic [11:0] b_addrA, b_addrB;
  logic [31:0] b_doutA = 32'd0, b_doutB = 32'd0;
  logic [63:0] b_data;
  logic [15:0] b_stall;

  mdl_bdy_stream_tx u_big (
    .iSYS_CLK(clk), .iSYS_RST(b_rst), .iFSM_START(b_start), .oFSM_DONE(b_done),
    .oB_en(b_en), .oB_addrA(b_addrA), .oB_addrB(b_addrB),
    .iB_doutA(b_doutA), .iB_doutB(b_doutB),
    .oWm_Tvalid(b_vld), .iWm_Tready(b_rdy), .oWm_Tdata(b_data), .oWm_Tlast(b_last)
`ifdef MDL_TX_STALL_CNT_EN
    , .oSTALL_CNT(b_stall)
`endif
  );
`ifndef MDL_TX_STALL_CNT_EN
  assign b_stall = 16'd0;
`endif

  always @(posedge clk) begin
    if (b_en) begin
      b_doutA <= 32'h100 + {20'd0, b_addrA};
      b_doutB <= 32'h100 + {20'd0, b_addrB};
    end
  end

  // ---------------- small-instance cycle driver and monitor ----------------
  logic [63:0] bq [$];
  logic        lq [$];
  int cyc_n = 0, first_en = -1, first_vld = -1, done_cnt = 0, done_cyc = -1, last_cyc = -1;

  task automatic clear_rec();
    bq.delete();
    lq.delete();
    first_en = -1;
    first_vld = -1;
    done_cnt = 0;
    done_cyc = -1;
    last_cyc = -1;
  endtask

  task automatic cyc(input logic start, input logic rdy, input logic rst);
    @(posedge clk);
    #1;
    s_start = start;
    s_rdy   = rdy;
    s_rst   = rst;
    #1;
    cyc_n++;
    if (s_en && first_en < 0) first_en = cyc_n;
    if (s_vld && first_vld < 0) first_vld = cyc_n;
    if (s_vld && s_rdy && !s_rst) begin
      bq.push_back(s_data);
      lq.push_back(s_last);
      if (s_last) last_cyc = cyc_n;
    end
    if (s_done) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
  endtask

  initial begin
    int n0;
    int nlast;
    int bk;
    int nd;
    int post;
    int last_idx;

    // reset state
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("rst_tvalid", 64'(s_vld), 64'd0);
    chk("rst_tlast", 64'(s_last), 64'd0);
    chk("rst_done", 64'(s_done), 64'd0);
    chk("rst_en", 64'(s_en), 64'd0);
    chk("rst_tdata", s_data, 64'd0);
    chk("rst_addrA", 64'(s_addrA), 64'd0);
    chk("rst_addrB", 64'(s_addrB), 64'd1);

    // reset wins over a simultaneous start
    clear_rec();
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("rst_vs_start_en", 64'(first_en), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_vs_start_beats", 64'(bq.size()), 64'd0);

    // frame with ready held high
    clear_rec();
    cyc(1'b1, 1'b1, 1'b0);
    n0 = cyc_n;
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("lat_first_en", 64'(first_en), 64'(n0 + 1));
    chk("lat_first_vld", 64'(first_vld), 64'(n0 + 2));
    chk("t1_beats", 64'(bq.size()), 64'd4);
    for (int k = 0; k < 4 && k < bq.size(); k++) begin
      chk($sformatf("t1_data%0d", k), bq[k], exp_beat(k));
      chk($sformatf("t1_last%0d", k), 64'(lq[k]), 64'(k == 3));
    end
    chk("t1_last_cyc", 64'(last_cyc), 64'(n0 + 5));
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    chk("t1_done_cyc", 64'(done_cyc), 64'(last_cyc + 1));
`ifdef MDL_TX_STALL_CNT_EN
    chk("t1_stall", 64'(s_stall), 64'd0);
`endif

    // frame with ready low for ten cycles from the first valid cycle
    clear_rec();
    cyc(1'b1, 1'b1, 1'b0);
    n0 = cyc_n;
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      chk($sformatf("t2_hold_vld%0d", i), 64'(s_vld), 64'd1);
      chk($sformatf("t2_hold_data%0d", i), s_data, 64'h00000101_00000100);
    end
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("t2_beats", 64'(bq.size()), 64'd4);
    for (int k = 0; k < 4 && k < bq.size(); k++) begin
      chk($sformatf("t2_data%0d", k), bq[k], exp_beat(k));
      chk($sformatf("t2_last%0d", k), 64'(lq[k]), 64'(k == 3));
    end
    chk("t2_done_cnt", 64'(done_cnt), 64'd1);
`ifdef MDL_TX_STALL_CNT_EN
    chk("t2_stall", 64'(s_stall), 64'd10);
`endif

    // starts pulsed in RUN and DONE are ignored; a start the cycle after DONE begins frame two
    clear_rec();
    for (int i = 0; i < 18; i++) begin
      cyc((i == 0) || (i == 2) || (i == 6) || (i == 7), 1'b1, 1'b0);
      if (i == 6) chk("t3_done_at_6", 64'(s_done), 64'd1);
    end
    chk("t3_beats", 64'(bq.size()), 64'd8);
    for (int k = 0; k < 8 && k < bq.size(); k++) begin
      chk($sformatf("t3_data%0d", k), bq[k], exp_beat(k % 4));
      chk($sformatf("t3_last%0d", k), 64'(lq[k]), 64'((k % 4) == 3));
    end
    chk("t3_done_cnt", 64'(done_cnt), 64'd2);
`ifdef MDL_TX_STALL_CNT_EN
    chk("t3_stall", 64'(s_stall), 64'd0);
`endif

    // reset after beat 1 aborts the frame; a restart sends beat 0 again
    clear_rec();
    for (int i = 0; i < 13; i++) begin
      cyc(i == 0, 1'b1, i == 4);
      if (i == 5) chk("t4_vld_after_rst", 64'(s_vld), 64'd0);
    end
    chk("t4_beats", 64'(bq.size()), 64'd2);
    chk("t4_no_done", 64'(done_cnt), 64'd0);
    clear_rec();
    for (int i = 0; i < 10; i++) cyc(i == 0, 1'b1, 1'b0);
    chk("t4_restart_beats", 64'(bq.size()), 64'd4);
    if (bq.size() > 0) chk("t4_restart_beat0", bq[0], 64'h00000101_00000100);
    chk("t4_restart_done", 64'(done_cnt), 64'd1);

    // full 4096-coefficient frame with ready alternating
    @(posedge clk); #1; b_rst = 1'b1;
    @(posedge clk); #1; b_rst = 1'b0; b_start = 1'b1;
    @(posedge clk); #1; b_start = 1'b0;
    nlast = 0; bk = 0; nd = 0; post = 0; last_idx = -1;
    for (int i = 0; i < 12000 && post < 6; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      b_rdy = (i % 2) == 0;
      #1;
      if (b_vld && b_rdy) begin
        chk($sformatf("t5_data%0d", bk), b_data, exp_beat(bk));
        if (b_last) begin
          nlast++;
          last_idx = bk;
        end
        bk++;
      end
      if (b_done) nd++;
      if (nd > 0) post++;
    end
    chk("t5_beats", 64'(bk), 64'd2048);
    chk("t5_nlast", 64'(nlast), 64'd1);
    chk("t5_last_idx", 64'(last_idx), 64'd2047);
    chk("t5_done_cnt", 64'(nd), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdl_bdy_stream_tx.md
MDL_BDY_STREAM_TX -- requirements
Module: mdl_bdy_stream_tx

Interface
REQ-001 SHALL have parameter PRM_ADDR, default 12, meaning the BRAM address width.
REQ-002 SHALL have parameter PRM_COEFFS, default 4096, meaning the number of 32-bit coefficients sent per frame; it is even and ≤ 2^PRM_ADDR.
REQ-003 SHALL have parameter PRM_DRAM, default 32, meaning the coefficient word width.
REQ-004 SHALL have parameter PRM_DAXI, default 64, meaning the stream data width, equal to 2*PRM_DRAM.
REQ-005 SHALL have port iSYS_CLK, input, 1 bit: the single clock.
REQ-006 SHALL have port iSYS_RST, input, 1 bit: reset, which is synchronous and active-high.
REQ-007 SHALL have port iFSM_START, input, 1 bit: a one-cycle frame start request.
REQ-008 SHALL have port oFSM_DONE, output, 1 bit: a one-cycle frame-complete pulse.
REQ-009 SHALL have port oB_en, output, 1 bit: the BRAM read enable for both ports.
REQ-010 SHALL have ports oB_addrA and oB_addrB, output, PRM_ADDR bits each: the even and odd coefficient addresses.
REQ-011 SHALL have ports iB_doutA and iB_doutB, input, PRM_DRAM bits each: the BRAM read data, valid one cycle after oB_en.
REQ-012 SHALL have port oWm_Tvalid, output, 1 bit: AXIS master valid.
REQ-013 SHALL have port iWm_Tready, input, 1 bit: AXIS master ready, driven by the write FIFO.
REQ-014 SHALL have port oWm_Tdata, output, PRM_DAXI bits: AXIS master data.
REQ-015 SHALL have port oWm_Tlast, output, 1 bit: AXIS master last.

Function
REQ-016 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-017 SHALL, in IDLE, move to RUN on iFSM_START=1; iFSM_START SHALL be ignored in every other state.
REQ-018 SHALL send PRM_COEFFS/2 beats per frame; beat k reads address 2k on port A and address 2k+1 on port B.
REQ-019 SHALL pack beat k as Tdata[31:0]=iB_doutA (coefficient 2k) and Tdata[63:32]=iB_doutB (coefficient 2k+1).
REQ-020 SHALL buffer read data in a 2-entry output FIFO and issue a read only when the in-flight reads plus occupied entries are fewer than 2, so no data is lost under backpressure.
REQ-021 SHALL keep sustained throughput at 1 beat/cycle while iWm_Tready=1.
REQ-022 SHALL meet this latency: iFSM_START sampled at edge t gives the first oB_en in cycle t+1 and the first oWm_Tvalid in cycle t+2.
REQ-023 SHALL accept a beat only when oWm_Tvalid=1 and iWm_Tready=1 in the same cycle.
REQ-024 SHALL hold oWm_Tdata and oWm_Tlast stable while oWm_Tvalid=1 and iWm_Tready=0.
REQ-025 SHALL NOT deassert oWm_Tvalid before its beat is accepted.
REQ-026 SHALL assert oWm_Tlast only on beat PRM_COEFFS/2-1.
REQ-027 SHALL move from RUN to DRAIN after the last read is issued, and from DRAIN to DONE on the handshake of the Tlast beat.
REQ-028 SHALL, in DONE, assert oFSM_DONE for exactly one cycle and then return to IDLE; a new start is accepted from the next cycle.
REQ-029 SHALL wrap the read address counter to 0 at frame end; the address SHALL never exceed PRM_COEFFS-1.
REQ-030 SHALL let iWm_Tready toggle every cycle with no beat duplicated, dropped or reordered.
REQ-031 SHALL keep oB_en=0 whenever no read is issued, and oB_addrA/oB_addrB SHALL be don't-care while oB_en=0.

Reset
REQ-032 SHALL, on iSYS_RST=1 at a clock edge, go to IDLE, set oWm_Tvalid=0, oWm_Tlast=0, oFSM_DONE=0, oB_en=0, oWm_Tdata=0, oB_addrA=0 and oB_addrB=1, and empty the buffer.
REQ-033 SHALL, on reset mid-frame, abort the frame: no further beats and no oFSM_DONE pulse for the aborted frame.
REQ-034 SHALL give reset priority over a simultaneous iFSM_START.

Configuration
REQ-035 SHALL, when macro MDL_TX_STALL_CNT_EN is defined, add output oSTALL_CNT (16 bits), which counts cycles with oWm_Tvalid=1 and iWm_Tready=0, saturates at 16'hFFFF, clears on accepted start and on reset, and holds its value after DONE.
REQ-036 SHALL, when MDL_TX_STALL_CNT_EN is not defined, have no oSTALL_CNT port and no counter logic, with all other behaviour identical.

Verification
REQ-037 SHALL cover: PRM_COEFFS=8, BRAM[i]=i+0x100, iWm_Tready=1 held -> 4 consecutive beats 0x00000101_00000100, 0x00000103_00000102, 0x00000105_00000104, 0x00000107_00000106; Tlast on beat 3 only; oFSM_DONE one cycle after beat 3.
REQ-038 SHALL cover: the same frame with iWm_Tready=0 for cycles t+2..t+11, then 1 -> Tdata holds 0x00000101_00000100 stable; the same 4 beats follow with no loss; oSTALL_CNT=10 when MDL_TX_STALL_CNT_EN is defined.
REQ-039 SHALL cover: iWm_Tready alternating 1/0 for PRM_COEFFS=4096 -> exactly 2048 beats in address order, one Tlast, one oFSM_DONE.
REQ-040 SHALL cover: iSYS_RST=1 after beat 1 of 4 -> oWm_Tvalid=0 the next cycle, no oFSM_DONE; a restart sends beat 0 again.
REQ-041 SHALL cover: iFSM_START pulsed during RUN -> ignored, exactly 4 beats; a second frame started the cycle after oFSM_DONE -> 4 more beats, first beat 0x00000101_00000100.
